sram_write_slave: RTL and testbench

SRAM_WRITE_SLAVE -- requirements
Module: sram_write_slave

---
 rtl/sram_write_slave.sv | 110 +++++++++++
 tb/tb_sram_write_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_slave.sv
// AXI-style write slave that turns write bursts into zero-latency SRAM byte writes.
// Optional define SRAM_WRITE_SLAVE_WLAST_CHECK_EN flags a misplaced or missing WLAST as SLVERR.
module sram_write_slave #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [3:0]        AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  output logic [7:0]        BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_we,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [7:0]        id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;
  logic              fixed_q;
  logic              err_q;
  logic              aw_hs;
  logic              w_hs;
  logic              last_beat;
  logic              wlast_bad;

  // Handshakes: a transfer happens on any rising edge where valid & ready are both 1;
  // ready/valid outputs are forced low during reset.
  assign AWREADY_S = ~rst & (state == IDLE);
  assign WREADY_S  = ~rst & (state == DATA);
  assign BVALID_S  = ~rst & (state == RESP);
  assign aw_hs     = AWVALID_S & AWREADY_S;
  assign w_hs      = WVALID_S & WREADY_S;
  assign last_beat = (cnt_q == len_q);

`ifdef SRAM_WRITE_SLAVE_WLAST_CHECK_EN
  assign wlast_bad = WLAST_S ^ last_beat;
`else
  assign wlast_bad = 1'b0;
`endif

  assign BID_S      = id_q;
  assign BRESP_S    = err_q ? 2'b10 : 2'b00;
  assign sram_addr  = addr_q;
  assign sram_wdata = WDATA_S;
  assign sram_we    = WSTRB_S & {4{w_hs & ~err_q}};
  assign fsm_state  = state;

  logic unused_ok;
  assign unused_ok = ^{WLAST_S, AWADDR_S[31:ADDR_W+2], AWADDR_S[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      id_q    <= 8'd0;
      addr_q  <= '0;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q    <= AWID_S;
            addr_q  <= AWADDR_S[ADDR_W+1:2];
            len_q   <= AWLEN_S;
            fixed_q <= ~AWBURST_S[0];
            err_q   <= (AWSIZE_S != 3'b010) | AWBURST_S[1];
            cnt_q   <= 4'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            // Address wraps naturally at 2^ADDR_W.
            if (!fixed_q) addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_q <= cnt_q + 4'd1;
            if (wlast_bad) err_q <= 1'b1;
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          if (BREADY_S) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_write_slave.sv
// Randomized bench for sram_write_slave with a transaction-level write/response model.
module tb_sram_write_slave;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    AWID_S;
  logic [31:0]   AWADDR_S;
  logic [3:0]    AWLEN_S;
  logic [2:0]    AWSIZE_S;
  logic [1:0]    AWBURST_S;
  logic          AWVALID_S;
  logic          AWREADY_S;
  logic [31:0]   WDATA_S;
  logic [3:0]    WSTRB_S;
  logic          WLAST_S;
  logic          WVALID_S;
  logic          WREADY_S;
  logic [7:0]    BID_S;
  logic [1:0]    BRESP_S;
  logic          BVALID_S;
  logic          BREADY_S;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_we;
  logic [1:0]    fsm_state;

  sram_write_slave #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_b   = 0;

  // expected beat: {check_addr, addr, data, we}; expected response: {id, resp}
  logic [AW+36:0] exp_q[$];
  logic [9:0]     exp_b[$];
  logic [AW-1:0]  obs_addr[$];
  logic [3:0]     obs_we[$];
  logic [7:0]     last_bid;
  logic [1:0]     last_bresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred or timed out unexpectedly", name);
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin : mon
    logic [AW+36:0] e;
    logic [9:0]     eb;
    if (rst) begin
      check("rst_awready", AWREADY_S, 0);
      check("rst_wready", WREADY_S, 0);
      check("rst_bvalid", BVALID_S, 0);
      check("rst_sram_we", sram_we, 0);
    end else begin
      if (WVALID_S && WREADY_S) begin
        obs_addr.push_back(sram_addr);
        obs_we.push_back(sram_we);
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          if (e[AW+36]) check("sram_addr", sram_addr, e[AW+35:36]);
          check("sram_wdata", sram_wdata, e[35:4]);
          check("sram_we", sram_we, e[3:0]);
        end
      end else begin
        check("sram_we_no_hs", sram_we, 0);
      end
      if (BVALID_S && BREADY_S) begin
        n_b++;
        last_bid   = BID_S;
        last_bresp = BRESP_S;
        if (exp_b.size() == 0) fail_now("unexpected_b");
        else begin
          eb = exp_b.pop_front();
          check("bid", BID_S, eb[9:2]);
          check("bresp", BRESP_S, eb[1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    tick();
    AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = size; AWBURST_S = burst;
    AWVALID_S = 1'b1;
    @(negedge clk);
    while (!AWREADY_S && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!AWREADY_S) fail_now("aw_timeout");
    else begin
      check("idle_wready", WREADY_S, 0);
      check("idle_bvalid", BVALID_S, 0);
    end
    tick();
    AWVALID_S = 1'b0;
  endtask

  // wlast_mode: 0 correct, 1 occasionally wrong, 2 asserted only on beat 1
  task automatic send_w(input logic [31:0] awaddr, input logic [3:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int gap_pct, input int wlast_mode,
                        input bit rnd_strb, input logic [3:0] strb_c, input logic [31:0] data_base,
                        input int stop_after, output bit err);
    logic [AW-1:0] wa, a;
    logic [31:0]   d;
    logic [3:0]    s;
    logic          wl;
    bit            fixed;
    int            n;
    wa    = awaddr[AW+1:2];
    err   = (size != 3'b010) || burst[1];
    fixed = (burst == 2'b00);
    for (int i = 0; i <= int'(len); i++) begin
      if (stop_after >= 0 && i == stop_after) begin
        WVALID_S = 1'b0;
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        WVALID_S = 1'b0;
        WDATA_S  = $urandom;
        WSTRB_S  = 4'hF;
        tick();
      end
      s = rnd_strb ? 4'($urandom_range(15)) : strb_c;
      d = data_base + i;
      case (wlast_mode)
        1:       wl = ($urandom_range(9) == 0) ? (i != int'(len)) : (i == int'(len));
        2:       wl = (i == 1);
        default: wl = (i == int'(len));
      endcase
      a = fixed ? wa : wa + i[AW-1:0];
      exp_q.push_back({~burst[1], a, d, err ? 4'h0 : s});
`ifdef SRAM_WRITE_SLAVE_WLAST_CHECK_EN
      if (wl != (i == int'(len))) err = 1'b1;
`endif
      WVALID_S = 1'b1; WDATA_S = d; WSTRB_S = s; WLAST_S = wl;
      n = 0;
      @(negedge clk);
      while (!WREADY_S && n < 20) begin
        n++;
        @(negedge clk);
      end
      if (!WREADY_S) fail_now("w_timeout");
      tick();
    end
    WVALID_S = 1'b0;
    WLAST_S  = 1'b0;
    @(negedge clk);
    check("bvalid_latency", BVALID_S, 1);
  endtask

  task automatic recv_b(input int hold, input logic [9:0] expb);
    BREADY_S = 1'b0;
    for (int k = 0; k < hold; k++) begin
      check("b_hold_bvalid", BVALID_S, 1);
      check("b_hold_bid", BID_S, expb[9:2]);
      check("b_hold_bresp", BRESP_S, expb[1:0]);
      check("b_hold_awready", AWREADY_S, 0);
      tick();
      @(negedge clk);
    end
    tick();
    BREADY_S = 1'b1;
    @(negedge clk);
    check("b_hs_awready", AWREADY_S, 0);
    tick();
    BREADY_S = 1'b0;
    @(negedge clk);
    check("post_b_awready", AWREADY_S, 1);
    check("post_b_bvalid", BVALID_S, 0);
  endtask

  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int gap_pct,
                         input int wlast_mode, input bit rnd_strb, input logic [3:0] strb_c,
                         input logic [31:0] data_base, input int hold);
    bit err;
    send_aw(id, addr, len, size, burst);
    send_w(addr, len, size, burst, gap_pct, wlast_mode, rnd_strb, strb_c, data_base, -1, err);
    exp_b.push_back({id, err ? 2'b10 : 2'b00});
    recv_b(hold, {id, err ? 2'b10 : 2'b00});
  endtask

  initial begin
    bit dummy;
    int nb_saved;
    rst = 1'b1;
    AWID_S = 0; AWADDR_S = 0; AWLEN_S = 0; AWSIZE_S = 0; AWBURST_S = 0; AWVALID_S = 0;
    WDATA_S = 0; WSTRB_S = 0; WLAST_S = 0; WVALID_S = 0; BREADY_S = 0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_awready", AWREADY_S, 1);
    check("reset_wready", WREADY_S, 0);
    check("reset_bvalid", BVALID_S, 0);

    // INCR burst at byte 0x100
    obs_addr.delete(); obs_we.delete();
    run_txn(8'h5A, 32'h100, 4'd3, 3'b010, 2'b01, 0, 0, 0, 4'hF, 32'hA0, 0);
    check("incr_nbeats", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) check("incr_addr_lit", obs_addr[i], 14'h40 + i);
    check("incr_bid_lit", last_bid, 8'h5A);
    check("incr_bresp_lit", last_bresp, 2'b00);

    // FIXED burst with WVALID gaps
    obs_addr.delete(); obs_we.delete();
    run_txn(8'h11, 32'h200, 4'd1, 3'b010, 2'b00, 60, 0, 0, 4'h3, 32'h55, 1);
    check("fixed_nbeats", obs_addr.size(), 2);
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      check("fixed_addr_lit", obs_addr[i], 14'h80);
      check("fixed_we_lit", obs_we[i], 4'h3);
    end
    check("fixed_bresp_lit", last_bresp, 2'b00);

    // unsupported burst type
    obs_addr.delete(); obs_we.delete();
    run_txn(8'h22, 32'h40, 4'd2, 3'b010, 2'b11, 0, 0, 0, 4'hF, 32'h77, 0);
    check("unsup_nbeats", obs_we.size(), 3);
    for (int i = 0; i < obs_we.size(); i++) check("unsup_we_lit", obs_we[i], 4'h0);
    check("unsup_bresp_lit", last_bresp, 2'b10);

    // wrap at top of SRAM with B backpressure
    obs_addr.delete(); obs_we.delete();
    run_txn(8'h33, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01, 0, 0, 0, 4'hF, 32'h1234_0000, 3);
    check("wrap_nbeats", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      check("wrap_addr0_lit", obs_addr[0], 14'h3FFF);
      check("wrap_addr1_lit", obs_addr[1], 14'h0000);
    end
    check("wrap_bid_lit", last_bid, 8'h33);

    // early WLAST
    run_txn(8'h44, 32'h400, 4'd2, 3'b010, 2'b01, 0, 2, 0, 4'hF, 32'hBEEF0, 0);
`ifdef SRAM_WRITE_SLAVE_WLAST_CHECK_EN
    check("wlast_bresp_lit", last_bresp, 2'b10);
`else
    check("wlast_bresp_lit", last_bresp, 2'b00);
`endif

    // reset mid-burst abandons the transaction
    nb_saved = n_b;
    send_aw(8'h66, 32'h800, 4'd3, 3'b010, 2'b01);
    send_w(32'h800, 4'd3, 3'b010, 2'b01, 0, 0, 0, 4'hF, 32'hC0, 2, dummy);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    BREADY_S = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_awready", AWREADY_S, 1);
      check("post_rst_bvalid", BVALID_S, 0);
      tick();
    end
    BREADY_S = 1'b0;
    check("post_rst_no_b", n_b, nb_saved);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [2:0] sz;
      logic [1:0] bt;
      sz = ($urandom_range(5) == 0) ? 3'($urandom_range(7)) : 3'b010;
      bt = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'($urandom_range(1));
      run_txn(8'($urandom), $urandom, 4'($urandom_range(15)), sz, bt, $urandom_range(40),
              1, 1, 4'h0, $urandom, $urandom_range(3));
    end

    tick();
    check("leftover_beats", exp_q.size(), 0);
    check("leftover_b", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
